// File: rtl/seg_pkg.sv
// Shared constants, converter state type and digit decoder for the
// six-digit seven-segment display driver.
package seg_pkg;

    localparam int          DIGITS    = 6;
    localparam logic [19:0] DATA_MAX  = 20'd999_999;

    localparam logic [7:0]  SEG_0     = 8'hC0;
    localparam logic [7:0]  SEG_1     = 8'hF9;
    localparam logic [7:0]  SEG_2     = 8'hA4;
    localparam logic [7:0]  SEG_3     = 8'hB0;
    localparam logic [7:0]  SEG_4     = 8'h99;
    localparam logic [7:0]  SEG_5     = 8'h92;
    localparam logic [7:0]  SEG_6     = 8'h82;
    localparam logic [7:0]  SEG_7     = 8'hF8;
    localparam logic [7:0]  SEG_8     = 8'h80;
    localparam logic [7:0]  SEG_9     = 8'h90;
    localparam logic [7:0]  SEG_BLANK = 8'hFF;
    localparam logic [7:0]  SEG_MINUS = 8'hBF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_e;

    function automatic logic [7:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = SEG_0;
            4'd1:    seg_decode = SEG_1;
            4'd2:    seg_decode = SEG_2;
            4'd3:    seg_decode = SEG_3;
            4'd4:    seg_decode = SEG_4;
            4'd5:    seg_decode = SEG_5;
            4'd6:    seg_decode = SEG_6;
            4'd7:    seg_decode = SEG_7;
            4'd8:    seg_decode = SEG_8;
            4'd9:    seg_decode = SEG_9;
            default: seg_decode = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/seg_dynamic_bcd_8421.sv
// Sequential double-dabble converter: 20-bit binary (saturated to 999_999)
// to six BCD digits in IDLE(1) + SHIFT(20) + DONE(1) cycles.
module bcd_8421
    import seg_pkg::*;
(
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [19:0] bin,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [23:0] bcd
);

    conv_state_e state_q;
    logic [19:0] bin_q;
    logic [23:0] acc_q;
    logic [4:0]  cnt_q;
    logic [23:0] acc_adj;
    logic [19:0] bin_sat;

    assign bin_sat = (bin > DATA_MAX) ? DATA_MAX : bin;

    always_comb begin
        acc_adj = acc_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5)
                acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
            bin_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        bin_q   <= bin_sat;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Adjust-then-shift across the joint accumulator/binary register.
                    {acc_q, bin_q} <= {acc_adj[22:0], bin_q, 1'b0};
                    cnt_q          <= cnt_q + 5'd1;
                    if (cnt_q == 5'd19)
                        state_q <= DONE;
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign bcd  = acc_q;

endmodule

// File: rtl/seg_dynamic.sv
// Six-digit multiplexed seven-segment driver: BCD conversion, leading-zero
// blanking, sign/decimal-point placement and registered digit scanning.
module seg_dynamic
    import seg_pkg::*;
#(
    parameter int CNT_MAX = 49_999
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [19:0] data,
    input  logic [5:0]  point,
    input  logic        sign,
    input  logic        seg_en,
    output logic [5:0]  sel,
    output logic [7:0]  seg
);

    localparam int CNT_W = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

    logic        busy, done;
    logic [23:0] bcd;

    logic [5:0]  sh_point_q;
    logic        sh_sign_q, sh_en_q;
    logic [23:0] digits_q;
    logic [5:0]  point_q;
    logic        sign_q, en_q;

    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       idx_q;
    logic [5:0]       sel_q, sel_d;
    logic [7:0]       seg_q, seg_d;
    logic [5:0]       sig;

    bcd_8421 u_bcd (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bin       (data),
        .start     (1'b1),
        .busy      (busy),
        .done      (done),
        .bcd       (bcd)
    );

    // Shadows track the inputs sampled alongside data; display updates atomically on done.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sh_point_q <= '0;
            sh_sign_q  <= 1'b0;
            sh_en_q    <= 1'b0;
            digits_q   <= '0;
            point_q    <= '0;
            sign_q     <= 1'b0;
            en_q       <= 1'b0;
        end else begin
            if (!busy) begin
                sh_point_q <= point;
                sh_sign_q  <= sign;
                sh_en_q    <= seg_en;
            end
            if (done) begin
                digits_q <= bcd;
                point_q  <= sh_point_q;
                sign_q   <= sh_sign_q;
                en_q     <= sh_en_q;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else if (cnt_q == CNT_W'(CNT_MAX)) begin
            cnt_q <= '0;
            idx_q <= (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // A digit is significant if it is the units digit or anything at or above it is lit.
    always_comb begin
        logic any;
        any = 1'b0;
        sig = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            any    = any | (digits_q[4*i +: 4] != 4'd0) | point_q[i];
            sig[i] = any | (i == 0);
        end
    end

    always_comb begin
        logic below_sig;
        below_sig = (idx_q == 3'd0) ? 1'b1 : sig[idx_q - 3'd1];
        if (sig[idx_q])
            seg_d = seg_decode(digits_q[{idx_q, 2'b00} +: 4]);
        else if (sign_q && below_sig)
            seg_d = SEG_MINUS;
        else
            seg_d = SEG_BLANK;
        if (point_q[idx_q])
            seg_d[7] = 1'b0;
        sel_d = 6'b000001 << idx_q;
        if (!en_q) begin
            sel_d = '0;
            seg_d = SEG_BLANK;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sel_q <= '0;
            seg_q <= SEG_BLANK;
        end else begin
            sel_q <= sel_d;
            seg_q <= seg_d;
        end
    end

    assign sel = sel_q;
    assign seg = seg_q;

endmodule

// File: tb/tb_seg_dynamic.sv
// Directed bench for seg_dynamic with a 4-cycle digit dwell.
module tb_seg_dynamic;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic [19:0] data;
    logic [5:0]  point;
    logic        sign;
    logic        seg_en;
    logic [5:0]  sel;
    logic [7:0]  seg;

    int errors = 0;
    int checks = 0;

    seg_dynamic #(.CNT_MAX(3)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .data      (data),
        .point     (point),
        .sign      (sign),
        .seg_en    (seg_en),
        .sel       (sel),
        .seg       (seg)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_sel(input logic [5:0] target, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge sys_clk);
            if (sel === target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // expected patterns packed as {d5,d4,d3,d2,d1,d0}
    task automatic check_frame(input string tag, input logic [47:0] exp);
        bit ok;
        wait_sel(6'h20, ok);
        if (ok) wait_sel(6'h01, ok);
        chk({tag, "_align"}, {47'd0, ok}, 48'd1);
        if (!ok) return;
        for (int d = 0; d < 6; d++) begin
            chk({tag, "_sel"}, {42'd0, sel}, {42'd0, 6'b000001 << d});
            chk({tag, "_seg"}, {40'd0, seg}, {40'd0, exp[8*d +: 8]});
            repeat (4) @(negedge sys_clk);
        end
    endtask

    initial begin
        bit ok;
        int n;

        // Reset state and hold until first conversion completes
        sys_rst_n = 1'b0;
        data      = 20'd123456;
        point     = 6'b0;
        sign      = 1'b0;
        seg_en    = 1'b1;
        repeat (3) @(negedge sys_clk);
        chk("rst_sel", {42'd0, sel}, 48'h0);
        chk("rst_seg", {40'd0, seg}, 48'hFF);
        sys_rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge sys_clk);
            chk("hold_sel", {42'd0, sel}, 48'h0);
            chk("hold_seg", {40'd0, seg}, 48'hFF);
        end

        // Full six-digit value
        repeat (30) @(negedge sys_clk);
        check_frame("full", 48'hF9_A4_B0_99_92_82);

        // Asynchronous reset mid-frame
        @(negedge sys_clk);
        #2 sys_rst_n = 1'b0;
        #1;
        chk("async_sel", {42'd0, sel}, 48'h0);
        chk("async_seg", {40'd0, seg}, 48'hFF);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;

        // Negative with blanking
        data = 20'd42;
        sign = 1'b1;
        repeat (50) @(negedge sys_clk);
        check_frame("neg", 48'hFF_FF_FF_BF_99_A4);

        // Decimal point forces leading zeros
        data  = 20'd5;
        sign  = 1'b0;
        point = 6'b000100;
        repeat (50) @(negedge sys_clk);
        check_frame("dp", 48'hFF_FF_FF_40_C0_92);

        // Saturation drops the sign
        data  = 20'd1_048_575;
        sign  = 1'b1;
        point = 6'b0;
        repeat (50) @(negedge sys_clk);
        check_frame("sat", 48'h90_90_90_90_90_90);

        // Enable removed then restored
        seg_en = 1'b0;
        ok = 1'b0;
        for (n = 1; n <= 45; n++) begin
            @(negedge sys_clk);
            if (sel === 6'h00 && seg === 8'hFF) begin
                ok = 1'b1;
                break;
            end
        end
        chk("en_off_blank", {47'd0, ok}, 48'd1);
        repeat (10) @(negedge sys_clk);
        chk("en_off_sel", {42'd0, sel}, 48'h0);
        chk("en_off_seg", {40'd0, seg}, 48'hFF);
        seg_en = 1'b1;
        ok = 1'b0;
        for (n = 1; n <= 46; n++) begin
            @(negedge sys_clk);
            if (sel !== 6'h00) begin
                ok = 1'b1;
                break;
            end
        end
        chk("en_on_resume", {47'd0, ok}, 48'd1);
        chk("en_on_onehot", {47'd0, $onehot(sel)}, 48'd1);
        check_frame("en_on", 48'h90_90_90_90_90_90);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
